// File: rtl/regfile_bist_pkg.sv
// regfile_bist_pkg: regfile geometry, BIST state encodings and test pattern shared by the BIST engine.
package regfile_bist_pkg;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int DATA_D = 32;
  localparam int BIST_ST_W = 2;
  localparam logic HIGH = 1'b1;
  localparam logic ENABLE = 1'b1;
  localparam logic DISABLE = 1'b0;
  localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(DATA_D - 1);
  typedef enum logic [BIST_ST_W-1:0] {
    BIST_IDLE  = 2'd0,
    BIST_WRITE = 2'd1,
    BIST_READ  = 2'd2,
    BIST_CHECK = 2'd3
  } bist_st_e;
  function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a, input logic p);
    return p ? ~DATA_W'(a) : DATA_W'(a);
  endfunction
endpackage

// File: rtl/regfile_bist.sv
// regfile_bist: two-pass write/read-back self-test of the single-port regfile, stopping at the first mismatch.
module regfile_bist
  import regfile_bist_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic              fail_pass,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata
);
  bist_st_e st, st_n;
  logic [ADDR_W-1:0] a, a_n;
  logic pn, pn_n;
  logic last, match, accept, fin;
  assign last = a == LAST_A;
  assign match = rdata == pattern(a, pn);
  assign accept = st == BIST_IDLE && start == HIGH;
  assign fin = st == BIST_CHECK && (!match || (last && pn));
  always_comb begin
    st_n = st;
    a_n = a;
    pn_n = pn;
    case (st)
      BIST_IDLE: if (accept) begin
        st_n = BIST_WRITE;
        a_n = '0;
        pn_n = 1'b0;
      end
      BIST_WRITE: begin
        st_n = last ? BIST_READ : BIST_WRITE;
        a_n = last ? '0 : a + 1'b1;
      end
      BIST_READ: st_n = BIST_CHECK;
      default: begin
        st_n = !match || (last && pn) ? BIST_IDLE : last ? BIST_WRITE : BIST_READ;
        a_n = match && !last ? a + 1'b1 : '0;
        pn_n = match && last ? 1'b1 : pn;
      end
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st <= BIST_IDLE;
      a <= '0;
      pn <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
      fail_addr <= '0;
      fail_data <= '0;
      fail_pass <= 1'b0;
    end else begin
      st <= st_n;
      a <= a_n;
      pn <= pn_n;
      done <= fin;
      if (accept) begin
        pass <= 1'b0;
        fail_addr <= '0;
        fail_data <= '0;
        fail_pass <= 1'b0;
      end else if (fin) begin
        pass <= match;
        if (!match) begin
          fail_addr <= a;
          fail_data <= rdata;
          fail_pass <= pn;
        end
      end
    end
  end
  // Port drive is decoded from state so an asynchronous reset silences the regfile at once.
  assign busy = st != BIST_IDLE;
  assign we = st == BIST_WRITE ? ENABLE : DISABLE;
  assign addr = st == BIST_IDLE ? '0 : a;
  assign wdata = we ? pattern(a, pn) : '0;
endmodule

// File: tb/tb_regfile_bist.sv
// tb_regfile_bist: directed vectors for the regfile BIST against a behavioural regfile with stuck-at-0 fault injection.
module tb_regfile_bist;
  import regfile_bist_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic busy, done, pass, fail_pass, we;
  logic [ADDR_W-1:0] fail_addr, addr;
  logic [DATA_W-1:0] fail_data, wdata, rdata;
  logic [DATA_W-1:0] mem [DATA_D];
  logic fen = 1'b0;
  logic [ADDR_W-1:0] fa = '0;
  logic [DATA_W-1:0] fm = '0;
  int tests = 0;
  int fails = 0;

  regfile_bist dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .pass(pass),
    .fail_addr(fail_addr), .fail_data(fail_data), .fail_pass(fail_pass),
    .we(we), .addr(addr), .wdata(wdata), .rdata(rdata)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DATA_D; i++) mem[i] <= '0;
    end else if (we) begin
      mem[addr] <= wdata & ~((fen && addr == fa) ? fm : '0);
    end
  end
  assign rdata = mem[addr];

  typedef struct {
    string nm;
    bit spam;
    bit fen;
    logic [ADDR_W-1:0] fa;
    logic [DATA_W-1:0] fm;
    int lat;
    int writes;
    logic exp_pass;
    logic [ADDR_W-1:0] exp_fa;
    logic [DATA_W-1:0] exp_fd;
    logic exp_fp;
  } vec_t;
  vec_t vecs [4];

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // Waits from the start edge for done; n is the number of edges after the start edge.
  task automatic wait_done(input bit keep, output int n, output int wc, output int bc, output int bad);
    logic [DATA_W-1:0] ew;
    n = -1; wc = 0; bc = 0; bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      start = keep;
      if (done) begin
        n = i;
        return;
      end
      if (busy) bc++;
      if (we) begin
        ew = wc < DATA_D ? DATA_W'(wc) : ~DATA_W'(wc - DATA_D);
        if (wdata !== ew || addr !== ADDR_W'(wc % DATA_D)) bad++;
        wc++;
      end
    end
  endtask

  task automatic kick();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
  endtask

  initial begin
    int n, wc, bc, bad;
    vecs[0] = '{"clean", 1'b0, 1'b0, 5'd0, 32'h0, 192, 64, 1'b1, 5'd0, 32'h0, 1'b0};
    vecs[1] = '{"p0fault", 1'b0, 1'b1, 5'd9, 32'h1, 52, 32, 1'b0, 5'd9, 32'h00000008, 1'b0};
    vecs[2] = '{"p1fault", 1'b0, 1'b1, 5'd5, 32'h8, 140, 64, 1'b0, 5'd5, 32'hFFFFFFF2, 1'b1};
    vecs[3] = '{"spam", 1'b1, 1'b0, 5'd0, 32'h0, 192, 64, 1'b1, 5'd0, 32'h0, 1'b0};
    #2;
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_pass", pass, 0);
    chk("rst_faddr", fail_addr, 0); chk("rst_fdata", fail_data, 0); chk("rst_fpass", fail_pass, 0);
    chk("rst_we", we, 0); chk("rst_addr", addr, 0); chk("rst_wdata", wdata, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int v = 0; v < 4; v++) begin
      fen = vecs[v].fen; fa = vecs[v].fa; fm = vecs[v].fm;
      kick();
      #1;
      chk({vecs[v].nm, "_first_we"}, {busy, we, addr, wdata}, {1'b1, 1'b1, 5'd0, 32'd0});
      wait_done(vecs[v].spam, n, wc, bc, bad);
      start = 1'b0;
      chk({vecs[v].nm, "_latency"}, n, vecs[v].lat);
      chk({vecs[v].nm, "_busy_cycles"}, bc, vecs[v].lat);
      chk({vecs[v].nm, "_writes"}, wc, vecs[v].writes);
      chk({vecs[v].nm, "_wpattern_errs"}, bad, 0);
      chk({vecs[v].nm, "_done_busy"}, busy, 0);
      chk({vecs[v].nm, "_pass"}, pass, vecs[v].exp_pass);
      chk({vecs[v].nm, "_fail_addr"}, fail_addr, vecs[v].exp_fa);
      chk({vecs[v].nm, "_fail_data"}, fail_data, vecs[v].exp_fd);
      chk({vecs[v].nm, "_fail_pass"}, fail_pass, vecs[v].exp_fp);
      @(negedge clk);
      chk({vecs[v].nm, "_done_pulse"}, {done, busy, we}, 3'b000);
      chk({vecs[v].nm, "_held_pass"}, pass, vecs[v].exp_pass);
    end

    // Reset during pass-1 WRITE at a=10.
    fen = 1'b0;
    kick();
    n = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (we && addr == 5'd10 && wdata == ~32'd10) begin
        n = i;
        break;
      end
    end
    chk("mid_reach_a10", n, 106);
    reset = 1'b1;
    #1;
    chk("mid_rst_outs", {busy, done, pass, we, addr, wdata, fail_addr, fail_data, fail_pass},
        {3'b000, 1'b0, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0});
    wc = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (we) wc++;
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (we) wc++;
    end
    chk("mid_rst_no_we", wc, 0);
    kick();
    wait_done(1'b0, n, wc, bc, bad);
    chk("after_rst_latency", n, 192);
    chk("after_rst_pass", pass, 1);

    // Back-to-back with start held: failing run, then its results clear on re-acceptance.
    fen = 1'b1; fa = 5'd9; fm = 32'h1;
    kick();
    wait_done(1'b1, n, wc, bc, bad);
    chk("b2b_latency", n, 52);
    chk("b2b_first", {pass, fail_addr, fail_data}, {1'b0, 5'd9, 32'h8});
    @(negedge clk);
    chk("b2b_restart", {busy, we, addr, wdata}, {1'b1, 1'b1, 5'd0, 32'd0});
    chk("b2b_cleared", {pass, fail_addr, fail_data, fail_pass}, {1'b0, 5'd0, 32'd0, 1'b0});
    wait_done(1'b0, n, wc, bc, bad);
    chk("b2b_second_latency", n, 51);
    chk("b2b_second_faddr", fail_addr, 9);

    $display("End of test - %0d assertions evaluated, %0d failures", tests, fails);
    $finish;
  end
endmodule

// File: doc/regfile_bist.md
# regfile_bist

Built-in self-test engine for the single-port register file. It acts as the initiator on the regfile port (`we`, `addr`, `indata`, `outdata`). On `start` it runs two passes over every entry, checks each readback against the expected pattern, and reports pass/fail together with the first failing address, data and pass number. It sits beside the regfile and has access to its port muxed in during test.

## Interface
Parameters (all from `regfile.h`; there are no module parameters):
- `ADDR_W`: regfile address width.
- `DATA_W`: regfile data width.
- `DATA_D`: regfile depth D, the number of entries tested (addresses 0..D-1).

Ports:
- `clk`  in  1  — single clock; all state changes on its rising edge.
- `reset`  in  1  — asynchronous, active-high; forces every output to its reset value immediately.
- `start`  in  1  — begins a test when sampled high in IDLE; ignored while busy.
- `busy`  out  1  — high from the cycle after `start` is accepted through the last check.
- `done`  out  1  — one-cycle pulse when the test finishes (pass or fail).
- `pass`  out  1  — result, valid from `done` and held until the next accepted `start`.
- `fail_addr`  out  `ADDR_W`  — address of the first mismatch.
- `fail_data`  out  `DATA_W`  — data read at the first mismatch.
- `fail_pass`  out  1  — pass number (0/1) of the first mismatch.
- `we`  out  1  — regfile write enable.
- `addr`  out  `ADDR_W`  — regfile address.
- `wdata`  out  `DATA_W`  — regfile write data; drives `indata`.
- `rdata`  in  `DATA_W`  — regfile read data, from `outdata`.

## Operation
- Pattern P(a) is address `a` zero-extended to `DATA_W` (truncated if `DATA_W` < `ADDR_W`).
  - Pass 0 writes and expects P(a).
  - Pass 1 writes and expects ~P(a).
- FSM states:
  - IDLE: waits for `start`.
  - WRITE: one address per cycle, a = 0..D-1, `we`=1.
  - READ: drives `addr`=a with `we`=0.
  - CHECK: holds `addr`, compares `rdata` with the expected value.
- Read order is a = 0..D-1 after all writes of that pass complete.
- Transitions:
  - IDLE → WRITE on `start`.
  - WRITE(a=D-1) → READ(a=0).
  - READ → CHECK.
  - CHECK, match, a<D-1 → READ(a+1).
  - CHECK, match, a=D-1, pass 0 → WRITE(pass 1, a=0).
  - CHECK, match, a=D-1, pass 1 → IDLE with `pass`=1.
  - CHECK, mismatch → IDLE with `pass`=0. The test stops at the first error.
- On mismatch, register `fail_addr`=a, `fail_data`=`rdata` and `fail_pass`=current pass.
- Outside WRITE, `we`=0 and `wdata`=0. `addr` is 0 in IDLE.
- On accepting `start`, clear `pass`, `fail_addr`, `fail_data` and `fail_pass`.
- Address counter: `ADDR_W` bits. Terminal count is compared against D-1, never wrap-around, so a non-power-of-2 D works.

## Timing
- Reset values: `busy`=0, `done`=0, `pass`=0, `fail_addr`=0, `fail_data`=0, `fail_pass`=0, `we`=0, `addr`=0, `wdata`=0; state=IDLE.
- `start` sampled at edge k:
  - `busy`=1 from cycle k+1.
  - First write (`we`=1, `addr`=0, `wdata`=P(0)) is in cycle k+1.
- Read latency rule: `rdata` must be valid during CHECK, i.e. within one clock of `addr` being driven in READ. This covers both asynchronous-read and 1-cycle registered-read regfiles.
- Cycles per pass: D write cycles plus 2D read/check cycles = 3D.
- Full passing run:
  - `busy` high for 6D cycles.
  - `done`=1 and `busy`=0 in cycle k+6D+1; `pass`, `fail_*` valid in that same cycle.
- Failing run: `done` pulses in the cycle after the failing CHECK.
- `start` held high continuously: a new test is accepted in the cycle after `done` (IDLE is entered there).
- `start` while `busy`: ignored, with no effect on the running test.
- Reset mid-test: immediate abort; `we` drops asynchronously, so no further writes are issued. The regfile's own reset restores its contents.

## Structure
- Add to the shared `regfile.h`:
  - state width and encodings `BIST_IDLE`, `BIST_WRITE`, `BIST_READ`, `BIST_CHECK`.
  - `BIST_ST_W`.
- Use the existing `HIGH`, `ENABLE` and `DISABLE` macros.
- Single module, no sub-module. Pattern generation is a one-line function of address and pass.
- The port mux between the functional path and the BIST sits in the integrating level, not in this block.

## Test plan
Bench config for concrete values: D=32, `DATA_W`=32. Each bench instantiates the real regfile.
- Clean run: `start` at edge k → `we` in cycles k+1..k+32 with `wdata`=0..31; `done`=1, `pass`=1 at cycle k+193; `busy` high exactly 192 cycles.
- Pass-0 fault: regfile wrapper forces bit0 of entry 9 to 0 → `done` with `pass`=0, `fail_addr`=9, `fail_data`=0x00000008, `fail_pass`=0; no pass-1 writes occur.
- Pass-1 fault: force bit3 of entry 5 to 0 → `pass`=0, `fail_addr`=5, `fail_data`=0xFFFFFFF2, `fail_pass`=1.
- `start` pulsed every cycle during a run → exactly one `done` pulse, at the same cycle as the clean run; results are unchanged.
- Reset asserted during pass-1 WRITE at a=10 → all outputs 0 within the same cycle, no `we` after reset; a subsequent `start` gives `pass`=1.
- Back-to-back: `start` held high → the second run begins in the cycle after `done`; the first run's `pass`/`fail_*` are cleared on acceptance.
